// File: rtl/dz11_pacer_if.sv
// dz11_pacer_if: LPR, transmit-request and completion-report signals of the DZ11 pacer
interface dz11_pacer_if;
    logic        lprwrite;
    logic [12:0] lprdata;
    logic        fast;
    logic [7:0]  txreq;
    logic        done_valid;
    logic [2:0]  done_line;
    logic        done_ready;
    logic [7:0]  busy;
    modport master (
        output lprwrite, lprdata, fast, txreq, done_ready,
        input  done_valid, done_line, busy
    );
    modport slave (
        input  lprwrite, lprdata, fast, txreq, done_ready,
        output done_valid, done_line, busy
    );
endinterface

// File: rtl/dz11_pacer.sv
// dz11_pacer: per-line DZ11 transmit character-time pacer with round-robin completion reports
module dz11_pacer #(
    parameter int CLKPERUS = 100
) (
    input logic CLOCK,
    input logic RESET,
    dz11_pacer_if.slave bus
);
    localparam int PW = CLKPERUS > 1 ? $clog2(CLKPERUS) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, WAITLOW = 2'd3;
    localparam logic [14:0] BITUS [16] = '{
        15'd20000, 15'd13333, 15'd9091, 15'd7435, 15'd6667, 15'd3333, 15'd1667, 15'd833,
        15'd556, 15'd500, 15'd417, 15'd278, 15'd208, 15'd139, 15'd104, 15'd52
    };
    logic [PW-1:0] pre;
    logic          tick;
    logic [3:0]    speed [8];
    logic [1:0]    clen [8];
    logic [7:0]    stop, par;
    logic [17:0]   count [8];
    logic [1:0]    state [8];
    logic [17:0]   nchar [8];
    logic [7:0]    done;
    logic [2:0]    rr, sel;
    logic          accept;
    logic          unused_lpr;

    assign tick = pre == PW'(CLKPERUS - 1);
    assign accept = bus.done_valid && bus.done_ready;
    assign bus.done_valid = |done;
    assign bus.done_line = sel;
    assign unused_lpr = ^{bus.lprdata[12], bus.lprdata[7]};

    // free-running 1 us prescaler, cleared only by reset
    always_ff @(posedge CLOCK)
        pre <= (RESET || tick) ? '0 : pre + 1'b1;

    // character time in ticks and status flags per line from current registers
    always_comb begin
        for (int l = 0; l < 8; l++) begin
            nchar[l] = bus.fast ? 18'd1 :
                {3'b0, BITUS[speed[l]]} * {14'b0, 4'd7 + {2'b0, clen[l]} + {3'b0, par[l]} + {3'b0, stop[l]}};
            done[l] = state[l] == DONE;
            bus.busy[l] = state[l] == BUSY;
        end
    end

    // first DONE line at or above rr; scanning downward lets the nearest one win
    always_comb begin
        sel = '0;
        for (int i = 7; i >= 0; i--)
            sel = done[rr + 3'(i)] ? rr + 3'(i) : sel;
    end

    // round-robin pointer moves just past each accepted line
    always_ff @(posedge CLOCK)
        rr <= RESET ? 3'd0 : accept ? sel + 3'd1 : rr;

    // LPR settings, character timers and per-line state machines
    always_ff @(posedge CLOCK) begin
        for (int l = 0; l < 8; l++) begin
            if (RESET) begin
                speed[l] <= 4'd13;
                clen[l]  <= 2'd3;
                stop[l]  <= 1'b0;
                par[l]   <= 1'b0;
                count[l] <= '0;
                state[l] <= IDLE;
            end else begin
                if (bus.lprwrite && bus.lprdata[2:0] == 3'(l)) begin
                    speed[l] <= bus.lprdata[11:8];
                    clen[l]  <= bus.lprdata[4:3];
                    stop[l]  <= bus.lprdata[5];
                    par[l]   <= bus.lprdata[6];
                end
                case (state[l])
                    IDLE: if (bus.txreq[l]) begin
                        count[l] <= nchar[l];
                        state[l] <= BUSY;
                    end
                    BUSY: if (tick) begin
                        count[l] <= count[l] - 1'b1;
                        if (count[l] == 18'd1) state[l] <= DONE;
                    end
                    DONE: if (accept && sel == 3'(l)) state[l] <= WAITLOW;
                    default: if (!bus.txreq[l]) state[l] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dz11_pacer.sv
// tb_dz11_pacer: directed and randomized checks of dz11_pacer against a tick-time reference model
module tb_dz11_pacer;
    localparam int P = 2;
    logic CLOCK, RESET;
    dz11_pacer_if bus();
    dz11_pacer #(.CLKPERUS(P)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus.slave));

    int n_tests = 0, n_fail = 0;
    int bt [16] = '{20000, 13333, 9091, 7435, 6667, 3333, 1667, 833, 556, 500, 417, 278, 208, 139, 104, 52};
    // model phases: 0 idle, 1 timing, 2 awaiting report, 3 waiting for txreq low
    int m_ph [8], m_end [8], m_spd [8], m_cl [8], m_st [8], m_pa [8];
    int m_k, m_t, m_rr, m_acc, m_exp, c, c2;
    bit m_on = 0, m_tick, seen;

    initial begin
        CLOCK = 0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic wait_valid(input int maxc, output int cnt);
        cnt = 0;
        while (bus.done_valid !== 1'b1 && cnt < maxc) begin
            step(1);
            cnt++;
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < 8; i++)
            if (m_ph[(m_rr + i) % 8] == 2) return (m_rr + i) % 8;
        return -1;
    endfunction

    function automatic int chars(int l, bit f);
        return f ? 1 : bt[m_spd[l]] * (1 + 5 + m_cl[l] + m_pa[l] + (m_st[l] ? 2 : 1));
    endfunction

    function automatic logic [7:0] busy_exp();
        logic [7:0] b = '0;
        for (int l = 0; l < 8; l++) b[l] = m_ph[l] == 1;
        return b;
    endfunction

    // reference model: absolute tick count m_t; a character ends N ticks after its load
    initial forever begin
        @(posedge CLOCK);
        if (RESET) begin
            m_on = 1;
            m_k = 0;
            m_t = 0;
            m_rr = 0;
            for (int l = 0; l < 8; l++) begin
                m_ph[l] = 0; m_spd[l] = 13; m_cl[l] = 3; m_st[l] = 0; m_pa[l] = 0;
            end
        end else if (m_on) begin
            m_tick = (m_k % P) == P - 1;
            m_acc = pick();
            for (int l = 0; l < 8; l++) begin
                case (m_ph[l])
                    0: if (bus.txreq[l]) begin
                        m_ph[l] = 1;
                        m_end[l] = m_t + (m_tick ? 1 : 0) + chars(l, bus.fast);
                    end
                    1: if (m_tick && m_t + 1 == m_end[l]) m_ph[l] = 2;
                    2: if (m_acc == l && bus.done_ready) m_ph[l] = 3;
                    default: if (!bus.txreq[l]) m_ph[l] = 0;
                endcase
            end
            if (m_acc >= 0 && bus.done_ready) m_rr = (m_acc + 1) % 8;
            if (bus.lprwrite) begin
                m_spd[bus.lprdata[2:0]] = int'(bus.lprdata[11:8]);
                m_cl[bus.lprdata[2:0]]  = int'(bus.lprdata[4:3]);
                m_st[bus.lprdata[2:0]]  = int'(bus.lprdata[5]);
                m_pa[bus.lprdata[2:0]]  = int'(bus.lprdata[6]);
            end
            m_k++;
            if (m_tick) m_t++;
        end
    end

    // every cycle, compare outputs with the model on the falling edge
    initial forever begin
        @(negedge CLOCK);
        if (m_on) begin
            m_exp = pick();
            chk("cyc_valid", bus.done_valid, m_exp >= 0);
            if (m_exp >= 0) chk("cyc_line", bus.done_line, m_exp);
            chk("cyc_busy", bus.busy, busy_exp());
        end
    end

    initial begin
        bus.lprwrite = 0; bus.lprdata = '0; bus.fast = 0; bus.txreq = '0; bus.done_ready = 0;
        RESET = 1;
        step(2);
        RESET = 0;
        chk("rst_valid", bus.done_valid, 0);
        chk("rst_line", bus.done_line, 0);
        chk("rst_busy", bus.busy, 0);

        // 9600 8N1 on line 0: N = 1040
        bus.lprdata = 13'h0E18; bus.lprwrite = 1;
        step(1);
        bus.lprwrite = 0; bus.txreq[0] = 1; bus.done_ready = 1;
        wait_valid(3000, c);
        chk("t1_latency_window", c >= 1039 * P + 2 && c <= 1040 * P + 1, 1);
        chk("t1_line", bus.done_line, 0);
        step(1);
        chk("t1_accepted", bus.done_valid, 0);
        step(1);
        chk("t1_waitlow_no_reload", bus.busy[0], 0);
        bus.txreq[0] = 0;
        step(2);

        // line 5, 19200 5N1: N = 364
        bus.lprdata = 13'h0F05; bus.lprwrite = 1;
        step(1);
        bus.lprwrite = 0; bus.txreq[5] = 1;
        wait_valid(1000, c);
        chk("t2_latency_window", c >= 363 * P + 2 && c <= 364 * P + 1, 1);
        chk("t2_line", bus.done_line, 5);
        seen = 0;
        repeat (50) begin
            step(1);
            seen |= bus.done_valid;
        end
        chk("t2_no_retrigger", seen, 0);
        bus.txreq[5] = 0;
        step(2);

        // fast mode, all lines at once from rr = 0
        RESET = 1;
        step(1);
        RESET = 0; bus.fast = 1; bus.txreq = 8'hFF; bus.done_ready = 1;
        wait_valid(20, c);
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid", bus.done_valid, 1);
            chk("t3_line", bus.done_line, i);
            step(1);
        end
        chk("t3_drained", bus.done_valid, 0);
        bus.txreq = '0;
        step(2);

        // move rr to 3 by accepting line 2, then lines 2 and 6 finish together
        bus.txreq[2] = 1;
        wait_valid(20, c);
        chk("t4_prep_line", bus.done_line, 2);
        step(1);
        bus.txreq[2] = 0; bus.done_ready = 0;
        step(2);
        bus.txreq = 8'h44;
        wait_valid(20, c);
        chk("t4_first_line", bus.done_line, 6);
        step(20);
        chk("t4_hold_valid", bus.done_valid, 1);
        chk("t4_hold_line", bus.done_line, 6);
        bus.done_ready = 1;
        step(1);
        chk("t4_next_valid", bus.done_valid, 1);
        chk("t4_next_line", bus.done_line, 2);
        step(1);
        chk("t4_drained", bus.done_valid, 0);
        bus.txreq = '0; bus.fast = 0;
        step(2);

        // line 1 at 9600 8N1; LPR to 50 baud while in flight
        bus.lprdata = 13'h0E19; bus.lprwrite = 1;
        step(1);
        bus.lprwrite = 0; bus.txreq[1] = 1;
        step(5);
        c = 5;
        bus.lprdata = 13'h0019; bus.lprwrite = 1;
        step(1);
        c++;
        bus.lprwrite = 0;
        wait_valid(3000, c2);
        c += c2;
        chk("t5_old_speed_window", c >= 1039 * P + 2 && c <= 1040 * P + 1, 1);
        chk("t5_line", bus.done_line, 1);
        step(1);
        bus.txreq[1] = 0;
        step(1);
        bus.txreq[1] = 1;
        step(1);
        chk("t5_reload_busy", bus.busy[1], 1);
        seen = 0;
        repeat (1040 * P + 20) begin
            step(1);
            seen |= bus.done_valid;
        end
        chk("t5_slow_no_done", seen, 0);
        chk("t5_slow_still_busy", bus.busy[1], 1);

        // reset mid-character aborts everything; held txreq reloads afterwards
        bus.txreq |= 8'h18;
        step(3);
        chk("t6_busy_before", bus.busy & 8'h1A, 8'h1A);
        RESET = 1;
        step(1);
        RESET = 0;
        chk("t6_busy_cleared", bus.busy, 0);
        chk("t6_valid_cleared", bus.done_valid, 0);
        step(1);
        chk("t6_reload", bus.busy & 8'h1A, 8'h1A);
        bus.txreq = '0; RESET = 1;
        step(1);
        RESET = 0;

        // randomized traffic checked cycle by cycle against the model
        repeat (4000) begin
            bus.txreq ^= 8'($urandom & $urandom & $urandom);
            bus.done_ready = 1'($urandom_range(0, 1));
            bus.lprwrite = $urandom_range(0, 9) == 0;
            bus.lprdata = 13'($urandom);
            bus.fast = $urandom_range(0, 9) < 8;
            RESET = $urandom_range(0, 599) == 0;
            step(1);
        end
        RESET = 0;
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
